// File: rtl/full_adder_pkg.sv
// Shared constants for the adder family; the leaf cell is one bit wide.
// Pure definitions: no logic, no latency, no backpressure.
package full_adder_pkg;
  localparam int FA_WIDTH = 1;
endpackage

// File: rtl/full_adder_half_adder.sv
// Half adder leaf: sum = x ^ y, carry = x & y.
// Purely combinational, zero latency, no backpressure.
module full_adder_half_adder
  import full_adder_pkg::*;
(
  input  logic [FA_WIDTH-1:0] x,
  input  logic [FA_WIDTH-1:0] y,
  output logic [FA_WIDTH-1:0] sum,
  output logic [FA_WIDTH-1:0] carry
);
  assign sum   = x ^ y;
  assign carry = x & y;
endmodule

// File: rtl/full_adder.sv
// One-bit full adder with combinational S/Cout/P and a registered copy (1-cycle latency).
// No handshake or backpressure; sync reset clears only the registered copy.
module full_adder
  import full_adder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [FA_WIDTH-1:0] a,
  input  logic [FA_WIDTH-1:0] b,
  input  logic [FA_WIDTH-1:0] Cin,
  output logic [FA_WIDTH-1:0] S,
  output logic [FA_WIDTH-1:0] Cout,
  output logic [FA_WIDTH-1:0] P,
  output logic [FA_WIDTH-1:0] S_q,
  output logic [FA_WIDTH-1:0] Cout_q,
  output logic [FA_WIDTH-1:0] P_q
);
  logic [FA_WIDTH-1:0] ab_sum;
  logic [FA_WIDTH-1:0] ab_carry;
  logic [FA_WIDTH-1:0] pc_carry;

  full_adder_half_adder u_ha_ab (
    .x     (a),
    .y     (b),
    .sum   (ab_sum),
    .carry (ab_carry)
  );

  full_adder_half_adder u_ha_pc (
    .x     (ab_sum),
    .y     (Cin),
    .sum   (S),
    .carry (pc_carry)
  );

  // Propagate is the first stage's sum so skip/lookahead stages can tap it.
  assign P    = ab_sum;
  assign Cout = ab_carry | pc_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      S_q    <= '0;
      Cout_q <= '0;
      P_q    <= '0;
    end else begin
      S_q    <= S;
      Cout_q <= Cout;
      P_q    <= P;
    end
  end
endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: arithmetic model plus a scoreboard for the registered copy.
module tb_full_adder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a = 1'b0, b = 1'b0, cin = 1'b0;
  logic s, cout, p, s_q, cout_q, p_q;

  typedef struct packed {
    logic c;
    logic s;
    logic p;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  full_adder dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .Cin    (cin),
    .S      (s),
    .Cout   (cout),
    .P      (p),
    .S_q    (s_q),
    .Cout_q (cout_q),
    .P_q    (p_q)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic ia, input logic ib, input logic ic);
    logic [1:0] tot;
    exp_t e;
    tot = {1'b0, ia} + {1'b0, ib} + {1'b0, ic};
    e.c = tot[1];
    e.s = tot[0];
    e.p = (ia != ib);
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({cout_q, s_q, p_q} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_regs: got %b expected 000", {cout_q, s_q, p_q});
    end
    n_cmp++;
    if ({cout, s} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_comb: got %b expected 11", {cout, s});
    end
  endtask

  task automatic test_comb_sweep();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      exp_t e;
      v = 3'(i);
      {a, b, cin} = v;
      e = model(v[2], v[1], v[0]);
      #3;
      n_cmp++;
      if ({cout, s, p} !== e) begin
        n_fail++;
        $display("FAIL comb_sweep[%0d]: got %b expected %b", i, {cout, s, p}, e);
      end
    end
  endtask

  task automatic test_propagate();
    logic [2:0] vec [3];
    logic       exp_p [3];
    vec[0] = 3'b10x; exp_p[0] = 1'b1;
    vec[1] = 3'b110; exp_p[1] = 1'b0;
    vec[2] = 3'b001; exp_p[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      {a, b, cin} = vec[i];
      #3;
      n_cmp++;
      if (p !== exp_p[i]) begin
        n_fail++;
        $display("FAIL propagate[%0d]: got %b expected %b", i, p, exp_p[i]);
      end
    end
  endtask

  task automatic test_latency();
    logic [2:0] vec [2];
    exp_t got;
    vec[0] = 3'b110;
    vec[1] = 3'b100;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      {a, b, cin} = vec[i];
      sb.push_back(model(vec[i][2], vec[i][1], vec[i][0]));
      @(posedge clk);
      #1;
      got = {cout_q, s_q, p_q};
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL latency[%0d]: scoreboard empty, got %b", i, got);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL latency[%0d]: got %b expected %b", i, got, e);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t got;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      exp_t e;
      v = 3'(i);
      @(negedge clk);
      {a, b, cin} = v;
      rst = (i == 5);
      e = model(v[2], v[1], v[0]);
      sb.push_back(rst ? exp_t'(3'b000) : e);
      #1;
      n_cmp++;
      if ({cout, s, p} !== e) begin
        n_fail++;
        $display("FAIL midstream_comb[%0d]: got %b expected %b", i, {cout, s, p}, e);
      end
      @(posedge clk);
      #1;
      got = {cout_q, s_q, p_q};
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL midstream_reg[%0d]: scoreboard empty, got %b", i, got);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (got !== x) begin
          n_fail++;
          $display("FAIL midstream_reg[%0d]: got %b expected %b", i, got, x);
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_boundary();
    {a, b, cin} = 3'b111;
    #3;
    n_cmp++;
    if ({cout, s, p} !== 3'b110) begin
      n_fail++;
      $display("FAIL boundary_ones: got %b expected 110", {cout, s, p});
    end
    {a, b, cin} = 3'b000;
    #3;
    n_cmp++;
    if ({cout, s, p} !== 3'b000) begin
      n_fail++;
      $display("FAIL boundary_zeros: got %b expected 000", {cout, s, p});
    end
  endtask

  initial begin
    test_reset();
    test_comb_sweep();
    test_propagate();
    test_latency();
    test_reset_midstream();
    test_boundary();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation Complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
